// File: rtl/bus_mem_responder_pkg.sv
// Shared bus definitions for the memory responder slice.
// Holds bus widths, the read/write request tags, the cache-line beat
// count, the responder state encoding and the wrap-within-line helper.
package bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 64;
    localparam int unsigned BUS_TAG_WIDTH  = 13;
    localparam int unsigned LINE_BEATS     = 8;

    localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h1100;
    localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WAIT,
        ST_RESP
    } bus_state_e;

    // Word offset inside a 64-byte line; wraps modulo 8 for critical-word-first.
    function automatic logic [2:0] wrap_beat(input logic [2:0] base, input logic [2:0] beat);
        return base + beat;
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
//   master : initiator side (drives request beats, acknowledges responses)
//   slave  : responder side (acknowledges request beats, drives responses)
// Signals:
//   bus_reqcyc  request beat valid          bus_reqack  request beat acknowledge
//   bus_req     address / write data        bus_reqtag  request tag
//   bus_respcyc response beat valid         bus_respack response acknowledge
//   bus_resp    response data               bus_resptag response tag
interface bus_mem_responder_if;
    import bus_pkg::*;

    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

// File: rtl/bus_mem_responder_mem_array.sv
// Word-indexed backing store for the memory responder.
// One synchronous write port, one combinational read port; no reset, so
// contents survive a responder reset.
// Ports:
//   clk      write clock
//   wr_en    write strobe
//   wr_addr  word index to write
//   wr_data  write data
//   rd_addr  word index to read
//   rd_data  read data (combinational)
module bus_mem_array #(
    parameter int unsigned WORDS = 8192,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Line-oriented memory responder.
// A read header returns the 8-word line critical-word-first after LATENCY
// cycles; a write header is followed by 8 data beats stored with the same
// wrap order. Unknown tags are acknowledged and dropped.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    responder side of the request/response bus
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 8192
) (
    input  logic               clk,
    input  logic               reset,
    bus_mem_responder_if.slave bus
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned ADDR_MSB = AW + 2;

    bus_state_e                state_q, state_d;
    logic [AW-1:0]             word_q, word_d;
    logic [3:0]                beat_q, beat_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      reqack_q, reqack_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic                      accept;
    logic                      resp_done;
    logic [2:0]                rd_beat;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [AW-1:0]             rd_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_data;

    // Address bits outside the word index alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.bus_req[BUS_DATA_WIDTH-1:ADDR_MSB+1], bus.bus_req[2:0]};

    function automatic logic [AW-1:0] line_word(input logic [AW-1:0] base, input logic [2:0] beat);
        return {base[AW-1:3], wrap_beat(base[2:0], beat)};
    endfunction

    bus_mem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (BUS_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.bus_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    always_comb begin
        accept    = bus.bus_reqcyc && !reqack_q &&
                    (state_q == ST_IDLE || state_q == ST_WR_DATA);
        resp_done = respcyc_q && bus.bus_respack;
        // Registered response data must already hold the next word when a
        // beat completes, so the read port looks one beat ahead.
        rd_beat   = resp_done ? beat_q[2:0] + 3'd1 : beat_q[2:0];

        state_d   = state_q;
        word_d    = word_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        reqack_d  = accept;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        wr_en     = 1'b0;
        wr_addr   = line_word(word_q, beat_q[2:0]);
        rd_addr   = line_word(word_q, rd_beat);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.bus_reqtag == MEM_READ) begin
                        word_d  = bus.bus_req[ADDR_MSB:3];
                        beat_d  = '0;
                        cnt_d   = 8'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end else if (bus.bus_reqtag == MEM_WRITE) begin
                        word_d  = bus.bus_req[ADDR_MSB:3];
                        beat_d  = '0;
                        state_d = ST_WR_DATA;
                    end
                end
            end

            ST_WR_DATA: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'(LINE_BEATS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_RESP: begin
                // First RESP cycle loads the output registers; respcyc rises after it.
                if (!respcyc_q) begin
                    respcyc_d = 1'b1;
                    resp_d    = rd_data;
                    resptag_d = MEM_READ;
                end else if (bus.bus_respack) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'(LINE_BEATS - 1)) begin
                        state_d   = ST_IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                        resptag_d = '0;
                    end else begin
                        resp_d = rd_data;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.bus_reqack  = reqack_q;
    assign bus.bus_respcyc = respcyc_q;
    assign bus.bus_resp    = resp_q;
    assign bus.bus_resptag = resptag_q;

endmodule
